regfile_wb_queue: RTL and testbench
===================================

Name: regfile_wb_queue

Overview:
- Write-side front end for the 3-port register file (2 combinational read ports, write port wa3/wd3/we3 on rising clk, r0 reads as 0).
- Accepts writeback requests from producers (ALU, load unit) over a valid/ready handshake and buffers them in a small FIFO.
- Drains the FIFO into the write port at one write per cycle.
- Forwards pending (queued, not yet written) data onto the two read paths so consumers never see stale register values.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer has a write request
- in_ready  out  1  queue can accept a request this cycle
- in_addr  in  AW  destination register
- in_data  in  DW  write data
- wb_hold  in  1  1 = suspend draining this cycle
- rf_we3  out  1  write enable to register file
- rf_wa3  out  AW  write address to register file
- rf_wd3  out  DW  write data to register file
- qry_a1, qry_a2  in  AW  read addresses (same values driven to regfile ra1/ra2)
- rf_rd1, rf_rd2  in  DW  raw regfile read data
- fwd_rd1, fwd_rd2  out  DW  read data with pending writes merged in
- empty, full  out  1  queue status
- count  out  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, rst_n=0): head/tail pointers and count = 0, empty=1, full=0, in_ready=1, rf_we3=0, rf_wa3=0, rf_wd3=0. Entry contents are don't-care but must never be forwarded: all entry valid bits clear.
- Push: in_valid && in_ready at a rising edge. in_ready = !full, registered-state only; no combinational path from the pop side.
- A push with in_addr==0 is handshaken (consumed) but not enqueued; count is unchanged.
- Pop: rf_we3 = !empty && !wb_hold, combinational from registered state and wb_hold. When rf_we3=1, rf_wa3/rf_wd3 carry the head entry. The entry pops on the same edge on which the regfile commits it.
- When empty: rf_wa3=0, rf_wd3=0.
- Push and pop on the same edge: count unchanged; pointers both advance, wrapping modulo DEPTH.
- When full: no push that cycle, even if a pop occurs.
- Ordering: strict FIFO. Two queued writes to the same register are both written, in order; no coalescing.
- Forwarding, combinational, ports 1 and 2 independently:
  - qry_aN==0: fwd_rdN = 0.
  - Else, if any valid queued entry matches qry_aN: fwd_rdN = data of the youngest matching entry.
  - Else: fwd_rdN = rf_rdN.
  - The head entry being written this cycle still counts as queued.
  - in_data of a request being accepted this cycle is NOT forwarded; it becomes visible one cycle later.
- Reset mid-operation: all queued writes are discarded and rf_we3 drops immediately (asynchronously).
- Latency: request accepted at edge N, with empty queue and wb_hold=0 → rf_we3=1 during cycle N+1 → committed at edge N+1.

Test Plan:
- Single write: push r5=0x0000_00A5 into empty queue, wb_hold=0 → next cycle rf_we3=1, wa3=5, wd3=0xA5; qry_a1=5 before the commit edge gives fwd_rd1=0xA5; queue empty afterwards.
- Fill and hold: wb_hold=1, push r1..r4 = 0x11..0x44 → full=1, in_ready=0, count=4; a 5th request (r6=0x66) stalls. Release hold → writes 1,2,3,4 in order on 4 consecutive cycles; r6 is accepted on the edge after the first pop.
- Same-register ordering: wb_hold=1, push r7=0x1 then r7=0x2; qry_a2=7 with rf_rd2=0xDEAD → fwd_rd2=0x2. Release hold → wd3 sequence 0x1, 0x2.
- r0 handling: push r0=0xFFFF_FFFF → accepted, count stays 0, rf_we3 never asserts; qry_a1=0 gives fwd_rd1=0 regardless of rf_rd1.
- Simultaneous push/pop at count=2 with wrap-around across entry DEPTH-1→0 → count stays 2; drained order matches push order.
- Assert rst_n=0 mid-drain with 3 entries queued → rf_we3=0 immediately; after release empty=1 and no further writes occur.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the register file write port: buffers producer
// writes, drains one per cycle and forwards pending data onto both read paths.
module regfile_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     wb_hold,
  output logic                     rf_we3,
  output logic [AW-1:0]            rf_wa3,
  output logic [DW-1:0]            rf_wd3,
  input  logic [AW-1:0]            qry_a1,
  input  logic [AW-1:0]            qry_a2,
  input  logic [DW-1:0]            rf_rd1,
  input  logic [DW-1:0]            rf_rd2,
  output logic [DW-1:0]            fwd_rd1,
  output logic [DW-1:0]            fwd_rd2,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  typedef logic [PW-1:0] ptr_t;

  logic [AW-1:0] q_addr [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  ptr_t head, tail;
  logic [PW:0] cnt;
  logic accept, push_en, pop_en;

  assign empty    = (cnt == '0);
  assign full     = (cnt == (PW+1)'(DEPTH));
  assign in_ready = !full;
  assign count    = cnt;

  // Writes to r0 are handshaken but dropped: they would never be observable.
  assign accept  = in_valid && in_ready;
  assign push_en = accept && (in_addr != '0);
  assign pop_en  = !empty && !wb_hold;

  assign rf_we3 = pop_en;
  assign rf_wa3 = empty ? '0 : q_addr[head];
  assign rf_wd3 = empty ? '0 : q_data[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      q_vld <= '0;
    end else begin
      if (push_en) begin
        tail        <= tail + ptr_t'(1);
        q_vld[tail] <= 1'b1;
      end
      if (pop_en) begin
        head        <= head + ptr_t'(1);
        q_vld[head] <= 1'b0;
      end
      case ({push_en, pop_en})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      q_addr[tail] <= in_addr;
      q_data[tail] <= in_data;
    end
  end

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    ptr_t idx;
    fwd_rd1 = rf_rd1;
    fwd_rd2 = rf_rd2;
    idx     = head;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + ptr_t'(k);
      if (q_vld[idx] && (q_addr[idx] == qry_a1)) fwd_rd1 = q_data[idx];
      if (q_vld[idx] && (q_addr[idx] == qry_a2)) fwd_rd2 = q_data[idx];
    end
    if (qry_a1 == '0) fwd_rd1 = '0;
    if (qry_a2 == '0) fwd_rd2 = '0;
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: handshake, drain order, forwarding,
// r0 filtering, pointer wrap and asynchronous reset.
module tb_regfile_wb_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic          clk, rst_n, in_valid, in_ready, wb_hold;
  logic [AW-1:0] in_addr, rf_wa3, qry_a1, qry_a2;
  logic [DW-1:0] in_data, rf_wd3, rf_rd1, rf_rd2, fwd_rd1, fwd_rd2;
  logic          rf_we3, empty, full;
  logic [2:0]    count;

  int n_assert = 0;
  int n_fail   = 0;

  regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .wb_hold(wb_hold),
    .rf_we3(rf_we3), .rf_wa3(rf_wa3), .rf_wd3(rf_wd3),
    .qry_a1(qry_a1), .qry_a2(qry_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .fwd_rd1(fwd_rd1), .fwd_rd2(fwd_rd2),
    .empty(empty), .full(full), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; wb_hold = 1'b0;
    qry_a1 = '0; qry_a2 = '0; rf_rd1 = '0; rf_rd2 = '0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_we3", rf_we3, 0);
    chk("rst_wa3", rf_wa3, 0);
    chk("rst_wd3", rf_wd3, 0);
    rst_n = 1'b1;
    tick();

    // single write
    push_req(5, 32'h0000_00A5);
    qry_a1 = 5; rf_rd1 = 32'h0000_0123;
    #1;
    chk("sw_ready", in_ready, 1);
    chk("sw_no_fwd_same_cycle", fwd_rd1, 32'h123);
    tick();
    in_valid = 1'b0;
    #1;
    chk("sw_we3", rf_we3, 1);
    chk("sw_wa3", rf_wa3, 5);
    chk("sw_wd3", rf_wd3, 32'hA5);
    chk("sw_count", count, 1);
    chk("sw_fwd1", fwd_rd1, 32'hA5);
    tick();
    chk("sw_empty_after", empty, 1);
    chk("sw_we3_after", rf_we3, 0);
    chk("sw_wa3_after", rf_wa3, 0);
    chk("sw_wd3_after", rf_wd3, 0);
    chk("sw_fwd1_after", fwd_rd1, 32'h123);

    // fill and hold
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push_req(AW'(i), DW'(i * 32'h11));
      tick();
    end
    push_req(6, 32'h66);
    qry_a1 = 3; rf_rd1 = 32'hBEEF;
    #1;
    chk("fh_full", full, 1);
    chk("fh_ready", in_ready, 0);
    chk("fh_count", count, 4);
    chk("fh_fwd1", fwd_rd1, 32'h33);
    tick();
    chk("fh_stall_count", count, 4);
    chk("fh_hold_we3", rf_we3, 0);
    wb_hold = 1'b0;
    #1;
    chk("fh_d1_we3", rf_we3, 1);
    chk("fh_d1_wa3", rf_wa3, 1);
    chk("fh_d1_wd3", rf_wd3, 32'h11);
    tick();
    chk("fh_d2_wa3", rf_wa3, 2);
    chk("fh_d2_wd3", rf_wd3, 32'h22);
    chk("fh_d2_count", count, 3);
    chk("fh_d2_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("fh_d3_wa3", rf_wa3, 3);
    chk("fh_d3_count", count, 3);
    tick();
    chk("fh_d4_wa3", rf_wa3, 4);
    chk("fh_d4_wd3", rf_wd3, 32'h44);
    chk("fh_d4_count", count, 2);
    tick();
    chk("fh_d5_wa3", rf_wa3, 6);
    chk("fh_d5_wd3", rf_wd3, 32'h66);
    chk("fh_d5_count", count, 1);
    tick();
    chk("fh_empty", empty, 1);
    chk("fh_we3_idle", rf_we3, 0);

    // same-register ordering
    wb_hold = 1'b1;
    push_req(7, 32'h1);
    tick();
    push_req(7, 32'h2);
    tick();
    in_valid = 1'b0;
    qry_a2 = 7; rf_rd2 = 32'hDEAD;
    qry_a1 = 8; rf_rd1 = 32'h8888;
    #1;
    chk("sr_count", count, 2);
    chk("sr_fwd2_youngest", fwd_rd2, 32'h2);
    chk("sr_fwd1_miss", fwd_rd1, 32'h8888);
    wb_hold = 1'b0;
    #1;
    chk("sr_wd3_first", rf_wd3, 32'h1);
    chk("sr_fwd2_head_counts", fwd_rd2, 32'h2);
    tick();
    chk("sr_wd3_second", rf_wd3, 32'h2);
    chk("sr_wa3_second", rf_wa3, 7);
    chk("sr_fwd2_last", fwd_rd2, 32'h2);
    tick();
    chk("sr_empty", empty, 1);
    chk("sr_fwd2_rf", fwd_rd2, 32'hDEAD);

    // r0 handling
    push_req(0, 32'hFFFF_FFFF);
    #1;
    chk("r0_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    qry_a1 = 0; rf_rd1 = 32'h5555;
    qry_a2 = 0; rf_rd2 = 32'h7777;
    #1;
    chk("r0_count", count, 0);
    chk("r0_we3", rf_we3, 0);
    chk("r0_empty", empty, 1);
    chk("r0_fwd1", fwd_rd1, 0);
    chk("r0_fwd2", fwd_rd2, 0);

    // simultaneous push/pop with wrap
    wb_hold = 1'b1;
    push_req(10, 32'hA0);
    tick();
    push_req(11, 32'hB0);
    tick();
    wb_hold = 1'b0;
    push_req(12, 32'hC0);
    #1;
    chk("wr_p1_wa3", rf_wa3, 10);
    chk("wr_p1_wd3", rf_wd3, 32'hA0);
    chk("wr_p1_count", count, 2);
    tick();
    push_req(13, 32'hD0);
    #1;
    chk("wr_p2_wa3", rf_wa3, 11);
    chk("wr_p2_wd3", rf_wd3, 32'hB0);
    chk("wr_p2_count", count, 2);
    tick();
    push_req(14, 32'hE0);
    #1;
    chk("wr_p3_wa3", rf_wa3, 12);
    chk("wr_p3_wd3", rf_wd3, 32'hC0);
    chk("wr_p3_count", count, 2);
    tick();
    in_valid = 1'b0;
    #1;
    chk("wr_p4_wa3", rf_wa3, 13);
    chk("wr_p4_wd3", rf_wd3, 32'hD0);
    chk("wr_p4_count", count, 2);
    tick();
    chk("wr_p5_wa3", rf_wa3, 14);
    chk("wr_p5_wd3", rf_wd3, 32'hE0);
    chk("wr_p5_count", count, 1);
    tick();
    chk("wr_empty", empty, 1);

    // reset mid-drain
    wb_hold = 1'b1;
    push_req(1, 32'h101);
    tick();
    push_req(2, 32'h202);
    tick();
    push_req(3, 32'h303);
    tick();
    in_valid = 1'b0;
    wb_hold = 1'b0;
    qry_a1 = 2; rf_rd1 = 32'h4242;
    #1;
    chk("rs_count_pre", count, 3);
    chk("rs_we3_pre", rf_we3, 1);
    chk("rs_fwd1_pre", fwd_rd1, 32'h202);
    rst_n = 1'b0;
    #1;
    chk("rs_we3_async", rf_we3, 0);
    chk("rs_empty_async", empty, 1);
    chk("rs_count_async", count, 0);
    chk("rs_fwd1_cleared", fwd_rd1, 32'h4242);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rs_no_write", rf_we3, 0);
      chk("rs_empty_after", empty, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
